// File: rtl/approx_mul_pipe.sv
// Pipelined WIDTHxWIDTH unsigned multiplier with run-time exact / OR-compressed approximate mode.
// Define ERR_MON_EN to add the approximation error monitor (clr_stats, err_count, err_max).
module approx_mul_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8,
    parameter int STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
`ifdef ERR_MON_EN
    ,
    input  logic                 clr_stats,
    output logic [15:0]          err_count,
    output logic [2*WIDTH-1:0]   err_max
`endif
);

    localparam int unsigned P  = 2 * WIDTH;
    localparam int unsigned WU = WIDTH;
    localparam int unsigned K  = APPROX_COLS;

    logic           w_en;
    logic [P-1:0]   w_exact;
    logic [P-1:0]   w_approx;
    logic [P-1:0]   w_res;
    logic [P-1:0]   w_low;
    logic [P-1:0]   w_high;
    logic [4:0]     w_cnt;

    assign w_en     = !out_valid | out_ready;
    assign in_ready = w_en;
    assign w_exact  = P'(a) * P'(b);

    // Columns below K are OR-compressed; w_cnt counts set bits in column K-1 for the compensation term.
    always_comb begin
        w_low  = '0;
        w_high = '0;
        w_cnt  = '0;
        for (int unsigned i = 0; i < WU; i++) begin
            for (int unsigned j = 0; j < WU; j++) begin
                if (i + j >= K)
                    w_high = w_high + (P'(a[i] & b[j]) << (i + j));
                else
                    w_low = w_low | (P'(a[i] & b[j]) << (i + j));
                if (i + j == K - 1)
                    w_cnt = w_cnt + 5'(a[i] & b[j]);
            end
        end
        w_approx = w_high + (P'(w_cnt >= 5'd2) << K) + w_low;
    end

    assign w_res = mode ? w_approx : w_exact;

`ifdef ERR_MON_EN
    logic [P-1:0] w_diff;
    // A nonzero difference travels down the pipe only for mode=1 beats that actually differ.
    assign w_diff = !mode ? '0 :
                    (w_exact > w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic         w_pv;
        logic [P-1:0] w_pres;
        logic         r_vld;
        logic [P-1:0] r_res;
`ifdef ERR_MON_EN
        logic [P-1:0] w_pdiff;
        logic [P-1:0] r_diff;
`endif
        if (s == 0) begin : g_first
            assign w_pv   = in_valid;
            assign w_pres = w_res;
`ifdef ERR_MON_EN
            assign w_pdiff = w_diff;
`endif
        end else begin : g_next
            assign w_pv   = g_stage[s-1].r_vld;
            assign w_pres = g_stage[s-1].r_res;
`ifdef ERR_MON_EN
            assign w_pdiff = g_stage[s-1].r_diff;
`endif
        end

        // Data registers load only real beats so out holds its last value across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_res <= '0;
`ifdef ERR_MON_EN
                r_diff <= '0;
`endif
            end else if (w_en) begin
                r_vld <= w_pv;
                if (w_pv) begin
                    r_res <= w_pres;
`ifdef ERR_MON_EN
                    r_diff <= w_pdiff;
`endif
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign out       = g_stage[STAGES-1].r_res;

`ifdef ERR_MON_EN
    logic [P-1:0] w_odiff;
    assign w_odiff = g_stage[STAGES-1].r_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (clr_stats) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (out_valid && out_ready && (w_odiff != '0)) begin
            if (err_count != '1)
                err_count <= err_count + 16'd1;
            if (w_odiff > err_max)
                err_max <= w_odiff;
        end
    end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (WIDTH=4, APPROX_COLS=4, STAGES=3) against a column-count model.
module tb_approx_mul_pipe;
    localparam int W = 4;
    localparam int K = 4;
    localparam int S = 3;
    localparam int P = 2 * W;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [P-1:0]   out;
`ifdef ERR_MON_EN
    logic           clr_stats;
    logic [15:0]    err_count;
    logic [P-1:0]   err_max;
`endif

    always #5 clk = ~clk;

    approx_mul_pipe #(.WIDTH(W), .APPROX_COLS(K), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef ERR_MON_EN
        , .clr_stats(clr_stats), .err_count(err_count), .err_max(err_max)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: count partial products per column, then apply the mode rules arithmetically.
    function automatic int model(input int av, input int bv, input bit m);
        int cnt [2*W];
        int r;
        if (!m) return av * bv;
        for (int k = 0; k < 2*W; k++) cnt[k] = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                cnt[i+j] += ((av >> i) & 1) * ((bv >> j) & 1);
        r = 0;
        for (int k = 0; k < 2*W; k++)
            r += (k < K) ? ((cnt[k] > 0 ? 1 : 0) << k) : (cnt[k] << k);
        if (cnt[K-1] >= 2) r += (1 << K);
        return r % (1 << P);
    endfunction

    typedef struct { int v; int c; } exp_t;
    exp_t q[$];
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   held_v = 0;
    logic [P-1:0] held_out;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) held_v = 0;
        else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && held_v) chk("stall_hold", out, held_out);
            if (in_valid && in_ready) q.push_back('{model(a, b, mode), cyc});
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("out", out, e.v);
                    if (lat_chk) chk("latency", cyc - e.c, S);
                end
            end
            held_v   = out_valid && !out_ready;
            held_out = out;
        end
    end

    task automatic send(input int av, input int bv, input bit m);
        bit ok = 0;
        a = W'(av); b = W'(bv); mode = m; in_valid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", ok, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int stale;
        rst = 1; in_valid = 0; a = '0; b = '0; mode = 0; out_ready = 1;
`ifdef ERR_MON_EN
        clr_stats = 0;
`endif
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        chk("model_15x15_m1", model(15, 15, 1), 207);
        chk("model_15x15_m0", model(15, 15, 0), 225);
        chk("model_3x3_m1", model(3, 3, 1), 7);
        chk("model_0x15_m1", model(0, 15, 1), 0);
        chk("model_3x3_m0", model(3, 3, 0), 9);
        chk("model_2x2_m1", model(2, 2, 1), 4);

        send(15, 15, 1); send(15, 15, 0); send(3, 3, 1); send(0, 15, 1); send(3, 3, 0);
        drain();

        // Ten back-to-back beats with exact latency checking
        lat_chk = 1;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 0;
        drain();
        lat_chk = 0;

        // Fill the pipe, stall 5 cycles, release
        out_ready = 0;
        send(5, 7, 0); send(9, 6, 1); send(12, 13, 1);
        in_valid = 1; a = 4'd11; b = 4'd10; mode = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        drain();

        // Reset with beats in flight
        send(7, 7, 1); send(8, 9, 0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); if (out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("no_stale_after_rst", stale, 0);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        drain();

`ifdef ERR_MON_EN
        clr_stats = 1;
        @(posedge clk); #1;
        clr_stats = 0;
        chk("err_count_clr0", err_count, 0);
        chk("err_max_clr0", err_max, 0);
        send(15, 15, 1); send(3, 3, 1); send(2, 2, 1); send(3, 3, 0);
        drain();
        chk("err_count", err_count, 2);
        chk("err_max", err_max, 18);
        clr_stats = 1;
        @(posedge clk); #1;
        clr_stats = 0;
        chk("err_count_clr", err_count, 0);
        chk("err_max_clr", err_max, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
